// File: rtl/prog_loader_arbiter_if.sv
// Bus bundle between the program loader, the SAP-1 CPU read path,
// the 16x8 program memory and the arbiter that owns the memory port.
interface prog_loader_arbiter_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
);
    // loader / sequencing requests
    logic              load_start;
    logic              run_req;
    logic [ADDR_W:0]   ld_len;
    logic              ld_valid;
    logic [DATA_W-1:0] ld_data;
    logic              ld_ready;
    // CPU fetch/operand path
    logic [ADDR_W-1:0] cpu_addr;
    logic              cpu_rd;
    logic [DATA_W-1:0] cpu_data;
    logic              cpu_wait;
    logic              cpu_run;
    // memory port
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_read;
    logic              mem_write;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    // status
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] checksum;
    logic              err;

    // arbiter side
    modport slave (
        input  load_start, run_req, ld_len, ld_valid, ld_data,
        input  cpu_addr, cpu_rd, mem_rdata,
        output ld_ready, cpu_data, cpu_wait, cpu_run,
        output mem_addr, mem_read, mem_write, mem_wdata,
        output busy, done, checksum, err
    );

    // requesters + memory side
    modport master (
        output load_start, run_req, ld_len, ld_valid, ld_data,
        output cpu_addr, cpu_rd, mem_rdata,
        input  ld_ready, cpu_data, cpu_wait, cpu_run,
        input  mem_addr, mem_read, mem_write, mem_wdata,
        input  busy, done, checksum, err
    );
endinterface

// File: rtl/prog_loader_arbiter.sv
// Program memory port arbiter: sequences IDLE -> LOAD -> DONE -> RUN,
// writes a length-checked byte stream into program memory, then hands
// the port to the CPU read path and releases the control unit.
module prog_loader_arbiter #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
) (
    input logic                   clk,
    input logic                   reset,
    prog_loader_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2,
        ST_RUN  = 2'd3
    } state_t;

    localparam logic [ADDR_W:0] LEN_MAX = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] LEN_ONE = (ADDR_W + 1)'(1);

    state_t            state;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W:0]   remaining;
    logic              wr_en_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [DATA_W-1:0] wr_data_q;
    logic [DATA_W-1:0] cpu_data_q;
    logic [DATA_W-1:0] checksum_q;
    logic              err_q;

    logic              in_run;
    logic              ld_ready_int;
    logic              accept;
    logic              len_legal;

    // decoded qualifiers shared by the FSM and the output mux
    always_comb begin
        in_run       = (state == ST_RUN);
        ld_ready_int = (state == ST_LOAD) && (remaining != '0);
        accept       = bus.ld_valid && ld_ready_int;
        len_legal    = (bus.ld_len != '0) && (bus.ld_len <= LEN_MAX);
    end

    // sequencing FSM, write pipeline register, checksum and error flag
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            wr_ptr     <= '0;
            remaining  <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            cpu_data_q <= '0;
            checksum_q <= '0;
            err_q      <= 1'b0;
        end else begin
            // a write is only ever pending for the cycle after its accept
            wr_en_q <= 1'b0;
            if (in_run) begin
                cpu_data_q <= bus.mem_rdata;
            end
            case (state)
                ST_IDLE: begin
                    if (bus.load_start) begin
                        if (len_legal) begin
                            remaining  <= bus.ld_len;
                            wr_ptr     <= '0;
                            checksum_q <= '0;
                            err_q      <= 1'b0;
                            state      <= ST_LOAD;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end else if (bus.run_req) begin
                        state <= ST_RUN;
                    end
                end
                ST_LOAD: begin
                    if (accept) begin
                        wr_en_q    <= 1'b1;
                        wr_addr_q  <= wr_ptr;
                        wr_data_q  <= bus.ld_data;
                        wr_ptr     <= wr_ptr + ADDR_W'(1);
                        checksum_q <= checksum_q + bus.ld_data;
                        remaining  <= remaining - LEN_ONE;
                        if (remaining == LEN_ONE) begin
                            state <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_RUN;
                end
                ST_RUN: begin
                    if (bus.load_start) begin
                        if (len_legal) begin
                            remaining  <= bus.ld_len;
                            wr_ptr     <= '0;
                            checksum_q <= '0;
                            err_q      <= 1'b0;
                            state      <= ST_LOAD;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // memory port mux: CPU owns the port combinationally in RUN,
    // otherwise the registered loader write drives it
    always_comb begin
        bus.ld_ready  = ld_ready_int;
        bus.cpu_run   = in_run;
        bus.busy      = (state == ST_LOAD) || (state == ST_DONE);
        bus.done      = (state == ST_DONE);
        bus.checksum  = checksum_q;
        bus.err       = err_q;
        bus.mem_write = wr_en_q;
        bus.mem_wdata = wr_data_q;
        bus.mem_addr  = in_run ? bus.cpu_addr : wr_addr_q;
        bus.mem_read  = in_run && bus.cpu_rd;
        bus.cpu_data  = in_run ? bus.mem_rdata : cpu_data_q;
        bus.cpu_wait  = bus.cpu_rd && !in_run;
    end

endmodule

// File: tb/tb_prog_loader_arbiter.sv
// Directed bench for prog_loader_arbiter with a behavioural 16x8 memory.
module tb_prog_loader_arbiter;

    logic clk;
    logic reset;
    logic init_mem;
    logic clr_a0;
    int   a0_writes;
    int   n_checks;
    int   n_pass;
    logic [7:0] tb_mem [16];

    prog_loader_arbiter_if #(.ADDR_W(4), .DATA_W(8)) bif ();

    prog_loader_arbiter #(.ADDR_W(4), .DATA_W(8), .DEPTH(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // behavioural program memory: async read, write on rising edge
    assign bif.mem_rdata = tb_mem[bif.mem_addr];

    always @(posedge clk) begin
        if (init_mem) begin
            for (int i = 0; i < 16; i++) tb_mem[i] <= 8'hE0 + 8'(i);
        end else if (bif.mem_write) begin
            tb_mem[bif.mem_addr] <= bif.mem_wdata;
        end
        if (clr_a0) a0_writes <= 0;
        else if (bif.mem_write && bif.mem_addr == 4'd0) a0_writes <= a0_writes + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; init_mem = 1'b1; clr_a0 = 1'b1;
        bif.load_start = 0; bif.run_req = 0; bif.ld_len = '0; bif.ld_valid = 0;
        bif.ld_data = '0; bif.cpu_addr = '0; bif.cpu_rd = 0;
        #2;
        n_checks++; if ({bif.ld_ready, bif.cpu_run, bif.mem_write, bif.mem_read, bif.busy, bif.done, bif.err} !== 7'b0)
            $display("FAIL reset_flags got %b exp 0000000", {bif.ld_ready, bif.cpu_run, bif.mem_write, bif.mem_read, bif.busy, bif.done, bif.err}); else n_pass++;
        n_checks++; if ({bif.mem_addr, bif.mem_wdata, bif.checksum} !== 20'h0)
            $display("FAIL reset_buses got %h exp 00000", {bif.mem_addr, bif.mem_wdata, bif.checksum}); else n_pass++;
        tick(); tick();
        init_mem = 1'b0; clr_a0 = 1'b0;
        reset = 1'b1;
        tick();
        n_checks++; if ({bif.busy, bif.cpu_run, bif.ld_ready} !== 3'b000)
            $display("FAIL idle_after_reset got %b exp 000", {bif.busy, bif.cpu_run, bif.ld_ready}); else n_pass++;
    endtask

    task automatic test_idle_cpu();
        bif.cpu_addr = 4'd3; bif.cpu_rd = 1'b1;
        #1;
        n_checks++; if (bif.cpu_wait !== 1'b1) $display("FAIL idle_cpu_wait got %b exp 1", bif.cpu_wait); else n_pass++;
        n_checks++; if (bif.mem_read !== 1'b0) $display("FAIL idle_mem_read got %b exp 0", bif.mem_read); else n_pass++;
        tick();
        bif.cpu_rd = 1'b0; bif.cpu_addr = '0;
    endtask

    task automatic test_illegal_len();
        bif.load_start = 1'b1; bif.ld_len = 5'd0;
        tick();
        n_checks++; if ({bif.err, bif.busy, bif.mem_write, bif.ld_ready} !== 4'b1000)
            $display("FAIL len0 got %b exp 1000", {bif.err, bif.busy, bif.mem_write, bif.ld_ready}); else n_pass++;
        bif.ld_len = 5'd17;
        tick();
        bif.load_start = 1'b0;
        n_checks++; if ({bif.err, bif.busy, bif.mem_write, bif.cpu_run} !== 4'b1000)
            $display("FAIL len17 got %b exp 1000", {bif.err, bif.busy, bif.mem_write, bif.cpu_run}); else n_pass++;
        tick();
        n_checks++; if ({bif.err, bif.busy, bif.mem_write} !== 3'b100)
            $display("FAIL len17_hold got %b exp 100", {bif.err, bif.busy, bif.mem_write}); else n_pass++;
    endtask

    task automatic test_load5();
        logic [7:0] b [5];
        int done_seen;
        b = '{8'h10, 8'h21, 8'h32, 8'h43, 8'h54};
        done_seen = 0;
        // load_start together with run_req: load wins, err clears
        bif.load_start = 1'b1; bif.run_req = 1'b1; bif.ld_len = 5'd5;
        tick();
        bif.load_start = 1'b0; bif.run_req = 1'b0;
        n_checks++; if ({bif.busy, bif.ld_ready, bif.err, bif.cpu_run} !== 4'b1100)
            $display("FAIL load5_enter got %b exp 1100", {bif.busy, bif.ld_ready, bif.err, bif.cpu_run}); else n_pass++;
        for (int i = 0; i < 5; i++) begin
            bif.ld_valid = 1'b1; bif.ld_data = b[i];
            tick();
            if (bif.done === 1'b1) done_seen++;
            n_checks++; if (bif.mem_write !== 1'b1 || bif.mem_addr !== 4'(i) || bif.mem_wdata !== b[i])
                $display("FAIL load5_write%0d got we=%b a=%h d=%h exp we=1 a=%h d=%h", i, bif.mem_write, bif.mem_addr, bif.mem_wdata, 4'(i), b[i]); else n_pass++;
        end
        bif.ld_valid = 1'b0;
        n_checks++; if ({bif.done, bif.ld_ready, bif.busy} !== 3'b101)
            $display("FAIL load5_done got %b exp 101", {bif.done, bif.ld_ready, bif.busy}); else n_pass++;
        tick();
        if (bif.done === 1'b1) done_seen++;
        n_checks++; if ({bif.cpu_run, bif.busy, bif.mem_write} !== 3'b100)
            $display("FAIL load5_run got %b exp 100", {bif.cpu_run, bif.busy, bif.mem_write}); else n_pass++;
        n_checks++; if (done_seen !== 1) $display("FAIL load5_done_count got %0d exp 1", done_seen); else n_pass++;
        n_checks++; if (bif.checksum !== 8'hFA) $display("FAIL load5_checksum got %h exp fa", bif.checksum); else n_pass++;
        n_checks++; if ({tb_mem[0], tb_mem[1], tb_mem[2], tb_mem[3], tb_mem[4], tb_mem[5]} !== 48'h10_21_32_43_54_E5)
            $display("FAIL load5_mem got %h exp 10213243 54e5", {tb_mem[0], tb_mem[1], tb_mem[2], tb_mem[3], tb_mem[4], tb_mem[5]}); else n_pass++;
    endtask

    task automatic test_cpu_read();
        bif.cpu_addr = 4'd3; bif.cpu_rd = 1'b1;
        #1;
        n_checks++; if (bif.mem_addr !== 4'd3 || bif.mem_read !== 1'b1)
            $display("FAIL run_rd_port got a=%h rd=%b exp a=3 rd=1", bif.mem_addr, bif.mem_read); else n_pass++;
        n_checks++; if (bif.cpu_data !== 8'h43 || bif.cpu_wait !== 1'b0)
            $display("FAIL run_rd_data got d=%h wait=%b exp d=43 wait=0", bif.cpu_data, bif.cpu_wait); else n_pass++;
        tick();
        bif.cpu_rd = 1'b0; bif.cpu_addr = '0;
    endtask

    task automatic test_run_illegal();
        bif.load_start = 1'b1; bif.ld_len = 5'd17;
        tick();
        bif.load_start = 1'b0;
        n_checks++; if ({bif.err, bif.cpu_run, bif.busy} !== 3'b110)
            $display("FAIL run_len17 got %b exp 110", {bif.err, bif.cpu_run, bif.busy}); else n_pass++;
        n_checks++; if (bif.checksum !== 8'hFA) $display("FAIL run_len17_cksum got %h exp fa", bif.checksum); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int j;
        logic [7:0] exp_d;
        j = 0;
        bif.load_start = 1'b1; bif.ld_len = 5'd16; clr_a0 = 1'b1;
        tick();
        bif.load_start = 1'b0; clr_a0 = 1'b0;
        n_checks++; if ({bif.cpu_run, bif.busy, bif.err, bif.ld_ready} !== 4'b0101)
            $display("FAIL reload_enter got %b exp 0101", {bif.cpu_run, bif.busy, bif.err, bif.ld_ready}); else n_pass++;
        n_checks++; if (bif.checksum !== 8'h00) $display("FAIL reload_cksum_clr got %h exp 00", bif.checksum); else n_pass++;
        for (int k = 0; k < 40 && j < 16; k++) begin
            bif.ld_valid = (k % 2 == 0);
            exp_d = 8'h80 + 8'(j);
            bif.ld_data = exp_d;
            tick();
            if (k % 2 == 0) begin
                n_checks++; if (bif.mem_write !== 1'b1 || bif.mem_addr !== 4'(j) || bif.mem_wdata !== exp_d)
                    $display("FAIL reload_beat%0d got we=%b a=%h d=%h exp we=1 a=%h d=%h", j, bif.mem_write, bif.mem_addr, bif.mem_wdata, 4'(j), exp_d); else n_pass++;
                j++;
            end else begin
                n_checks++; if (bif.mem_write !== 1'b0 || bif.ld_ready !== 1'b1)
                    $display("FAIL reload_idle_beat got we=%b rdy=%b exp we=0 rdy=1", bif.mem_write, bif.ld_ready); else n_pass++;
            end
        end
        bif.ld_valid = 1'b0;
        n_checks++; if ({bif.ld_ready, bif.done, bif.mem_addr} !== {1'b0, 1'b1, 4'hF})
            $display("FAIL reload_last got rdy=%b done=%b a=%h exp rdy=0 done=1 a=f", bif.ld_ready, bif.done, bif.mem_addr); else n_pass++;
        tick();
        n_checks++; if (bif.cpu_run !== 1'b1 || bif.checksum !== 8'h78)
            $display("FAIL reload_end got run=%b ck=%h exp run=1 ck=78", bif.cpu_run, bif.checksum); else n_pass++;
        n_checks++; if (a0_writes !== 1) $display("FAIL reload_addr0_writes got %0d exp 1", a0_writes); else n_pass++;
        n_checks++; if (tb_mem[0] !== 8'h80 || tb_mem[15] !== 8'h8F)
            $display("FAIL reload_mem got %h/%h exp 80/8f", tb_mem[0], tb_mem[15]); else n_pass++;
    endtask

    task automatic test_reset_mid_load();
        bif.load_start = 1'b1; bif.ld_len = 5'd5;
        tick();
        bif.load_start = 1'b0;
        bif.ld_valid = 1'b1; bif.ld_data = 8'hA0; tick();
        bif.ld_data = 8'hA1; tick();
        bif.ld_data = 8'hA2; tick();
        n_checks++; if (bif.mem_write !== 1'b1 || bif.mem_addr !== 4'd2)
            $display("FAIL midrst_pending got we=%b a=%h exp we=1 a=2", bif.mem_write, bif.mem_addr); else n_pass++;
        bif.ld_valid = 1'b0;
        reset = 1'b0;
        #1;
        n_checks++; if ({bif.busy, bif.ld_ready, bif.mem_write, bif.cpu_run} !== 4'b0000)
            $display("FAIL midrst_async got %b exp 0000", {bif.busy, bif.ld_ready, bif.mem_write, bif.cpu_run}); else n_pass++;
        tick();
        reset = 1'b1;
        tick();
        n_checks++; if ({tb_mem[0], tb_mem[1], tb_mem[2]} !== 24'hA0_A1_82)
            $display("FAIL midrst_mem got %h exp a0a182", {tb_mem[0], tb_mem[1], tb_mem[2]}); else n_pass++;
        n_checks++; if ({bif.busy, bif.cpu_run, bif.checksum} !== 10'h0)
            $display("FAIL midrst_idle got %h exp 000", {bif.busy, bif.cpu_run, bif.checksum}); else n_pass++;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        test_reset();
        test_idle_cpu();
        test_illegal_len();
        test_load5();
        test_cpu_read();
        test_run_illegal();
        test_back_to_back();
        test_reset_mid_load();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
